// File: rtl/threshold_compress.sv
// Ternarizes signed preactivations against a low/high threshold pair and packs
// each group of N_TRITS trits into one base-3 code. Optional debug port: THRESHOLD_COMPRESS_TRITS_OUT_EN.
module threshold_compress #(
  parameter int OUTPUT_WIDTH = 8,
  localparam int COMPREG_WIDTH = OUTPUT_WIDTH * 5 / 4,
  localparam int N_TRITS = COMPREG_WIDTH / 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic signed [31:0]       data_i,
  input  logic        [31:0]       threshold_i,
  input  logic                     enable_i,
  output logic [OUTPUT_WIDTH-1:0]  data_o,
  output logic                     ready_o
`ifdef THRESHOLD_COMPRESS_TRITS_OUT_EN
  ,
  output logic [COMPREG_WIDTH-1:0] trits_o
`endif
);

  localparam int CNT_W = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TRITS - 1);

  // Output strobe: ready_o is a one-cycle valid pulse with no ready back-pressure;
  // data_o is meaningful from the pulse onward and holds until the next pulse.

  logic signed [31:0]        lo;
  logic signed [31:0]        hi;
  logic [1:0]                trit_code;
  logic [CNT_W-1:0]          cnt_q;
  logic [COMPREG_WIDTH-1:0]  trit_q;
  logic [COMPREG_WIDTH-1:0]  trit_next;
  logic [OUTPUT_WIDTH-1:0]   code;

  assign lo = {{16{threshold_i[15]}}, threshold_i[15:0]};
  assign hi = {{16{threshold_i[31]}}, threshold_i[31:16]};

  // The +1 test comes first so it wins when the thresholds are inverted.
  always_comb begin
    trit_code = 2'b00;
    if (data_i > hi) begin
      trit_code = 2'b01;
    end else if (data_i < lo) begin
      trit_code = 2'b11;
    end
  end

  always_comb begin
    trit_next = trit_q;
    for (int k = 0; k < N_TRITS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        trit_next[2*k +: 2] = trit_code;
      end
    end
  end

  function automatic logic [1:0] digit(input logic [1:0] enc);
    case (enc)
      2'b11:   digit = 2'd0;
      2'b01:   digit = 2'd2;
      default: digit = 2'd1;
    endcase
  endfunction

  // Horner evaluation, most significant trit first; every partial sum is
  // bounded by the final code, which always fits OUTPUT_WIDTH.
  always_comb begin
    code = '0;
    for (int k = N_TRITS - 1; k >= 0; k--) begin
      code = (code << 1) + code + {{(OUTPUT_WIDTH-2){1'b0}}, digit(trit_next[2*k +: 2])};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      trit_q  <= '0;
      data_o  <= '0;
      ready_o <= 1'b0;
`ifdef THRESHOLD_COMPRESS_TRITS_OUT_EN
      trits_o <= '0;
`endif
    end else begin
      ready_o <= 1'b0;
      if (enable_i) begin
        trit_q <= trit_next;
        if (cnt_q == LAST_IDX) begin
          cnt_q   <= '0;
          data_o  <= code;
          ready_o <= 1'b1;
`ifdef THRESHOLD_COMPRESS_TRITS_OUT_EN
          trits_o <= trit_next;
`endif
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_threshold_compress.sv
// Bench for threshold_compress: fixed vector table, hand-written multi-cycle
// sequences, and randomized traffic against an arithmetic reference model.
module tb_threshold_compress;

  logic               clk;
  logic               rst;
  logic signed [31:0] data;
  logic        [31:0] th;
  logic               enable;
  logic [7:0]         data_o;
  logic               ready_o;
`ifdef THRESHOLD_COMPRESS_TRITS_OUT_EN
  logic [9:0]         trits_o;
`endif

  threshold_compress dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .data_i      (data),
    .threshold_i (th),
    .enable_i    (enable),
    .data_o      (data_o),
    .ready_o     (ready_o)
`ifdef THRESHOLD_COMPRESS_TRITS_OUT_EN
    ,
    .trits_o     (trits_o)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         pulse_cnt = 0;
  int         last_pulse_cyc = -1;
  int         pulse_gap = -1;
  logic [7:0] exp_q[$];
  logic [9:0] exp_trits_q[$];
  int         grp[$];
  logic       exp_ready = 1'b0;
  logic [7:0] held_code = 8'h00;

  typedef struct {
    int         d[5];
    logic [7:0] exp_code;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // reference model: trit rules and base-3 packing expressed arithmetically
  function automatic int trit_of(input int d);
    int hi_v;
    int lo_v;
    hi_v = int'($signed(th[31:16]));
    lo_v = int'($signed(th[15:0]));
    if (d > hi_v) return 1;
    if (d < lo_v) return -1;
    return 0;
  endfunction

  function automatic logic [9:0] pack_trits(input int t0, t1, t2, t3, t4);
    int t[5];
    logic [9:0] r;
    t = '{t0, t1, t2, t3, t4};
    r = '0;
    for (int k = 0; k < 5; k++)
      r[2*k +: 2] = (t[k] == 1) ? 2'b01 : (t[k] == -1) ? 2'b11 : 2'b00;
    return r;
  endfunction

  // driver: apply one cycle of inputs, advance the model, compare outputs
  task automatic step(input int d, input logic en);
    int code;
    int p;
    data   = d;
    enable = en;
    @(posedge clk);
    cyc++;
    if (rst) begin
      grp.delete();
      exp_q.delete();
      exp_trits_q.delete();
      exp_ready = 1'b0;
      held_code = 8'h00;
    end else begin
      exp_ready = 1'b0;
      if (en) begin
        grp.push_back(trit_of(d));
        if (grp.size() == 5) begin
          code = 0;
          p = 1;
          for (int k = 0; k < 5; k++) begin
            code += (grp[k] + 1) * p;
            p *= 3;
          end
          exp_q.push_back(8'(code));
          exp_trits_q.push_back(pack_trits(grp[0], grp[1], grp[2], grp[3], grp[4]));
          held_code = 8'(code);
          exp_ready = 1'b1;
          grp.delete();
        end
      end
    end
    #1;
    check("ready", ready_o, exp_ready);
    check("data_hold", data_o, held_code);
    if (ready_o) begin
      pulse_cnt++;
      if (last_pulse_cyc >= 0) pulse_gap = cyc - last_pulse_cyc;
      last_pulse_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        check("sb_code", data_o, exp_q.pop_front());
`ifdef THRESHOLD_COMPRESS_TRITS_OUT_EN
        check("sb_trits", trits_o, exp_trits_q.pop_front());
`else
        void'(exp_trits_q.pop_front());
`endif
      end
    end
  endtask

  task automatic apply_reset(input int n, input logic en);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step(1000, en);
    rst = 1'b0;
  endtask

  task automatic run_group(input int d0, d1, d2, d3, d4);
    step(d0, 1'b1);
    step(d1, 1'b1);
    step(d2, 1'b1);
    step(d3, 1'b1);
    step(d4, 1'b1);
  endtask

  initial begin
    rst    = 1'b1;
    data   = '0;
    enable = 1'b0;
    th     = {16'd100, 16'hFF9C};

    vecs[0] = '{d: '{200, -200, 0, 100, -100}, exp_code: 8'h77};
    vecs[1] = '{d: '{1000, 1000, 1000, 1000, 1000}, exp_code: 8'hF2};
    vecs[2] = '{d: '{-1000, -1000, -1000, -1000, -1000}, exp_code: 8'h00};
    vecs[3] = '{d: '{5, 5, 5, 5, 5}, exp_code: 8'h79};

    // reset state, with enable held high to show reset wins
    apply_reset(2, 1'b1);
    check("reset_data", data_o, 8'h00);
    check("reset_ready", ready_o, 1'b0);

    // table-driven groups
    for (int v = 0; v < 4; v++) begin
      run_group(vecs[v].d[0], vecs[v].d[1], vecs[v].d[2], vecs[v].d[3], vecs[v].d[4]);
      check("table_code", data_o, vecs[v].exp_code);
      check("table_ready", ready_o, 1'b1);
`ifdef THRESHOLD_COMPRESS_TRITS_OUT_EN
      if (v == 0) check("table_trits", trits_o, 10'b00_00_00_11_01);
`endif
      step(0, 1'b0);
      check("table_ready_drop", ready_o, 1'b0);
      check("table_hold", data_o, vecs[v].exp_code);
    end

    // enable gap inside a partial group
    step(200, 1'b1);
    step(-200, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(7777, 1'b0);
      check("gap_ready_low", ready_o, 1'b0);
    end
    step(0, 1'b1);
    step(100, 1'b1);
    step(-100, 1'b1);
    check("gap_code", data_o, 8'h77);

    // reset mid-group discards the partial group
    step(1000, 1'b1);
    step(1000, 1'b1);
    step(1000, 1'b1);
    apply_reset(1, 1'b1);
    pulse_cnt = 0;
    run_group(-1000, -1000, -1000, -1000, -1000);
    check("rst_mid_code", data_o, 8'h00);
    step(0, 1'b0);
    step(0, 1'b0);
    check("rst_mid_pulses", pulse_cnt, 1);

    // back-to-back groups
    pulse_cnt = 0;
    last_pulse_cyc = -1;
    pulse_gap = -1;
    run_group(200, -200, 0, 100, -100);
    check("b2b_first", data_o, 8'h77);
    run_group(1000, 1000, 1000, 1000, 1000);
    check("b2b_second", data_o, 8'hF2);
    check("b2b_gap", pulse_gap, 5);
    check("b2b_pulses", pulse_cnt, 2);

    // randomized traffic, thresholds sometimes inverted, values near the edges
    for (int blk = 0; blk < 20; blk++) begin
      th[31:16] = 16'($signed($urandom_range(0, 60)) - 30);
      th[15:0]  = 16'($signed($urandom_range(0, 60)) - 30);
      if ($urandom_range(0, 9) == 0) apply_reset(1, $urandom_range(0, 1) == 1);
      for (int i = 0; i < 40; i++) begin
        step($signed($urandom_range(0, 100)) - 50, $urandom_range(0, 3) != 0);
      end
    end
    step(0, 1'b0);
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
